imem_loader: RTL

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and writes them sequentially into instruction memory. The CPU is held in reset until a complete, valid image has been written. On a malformed image the loader parks in an error state.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream (16-bit big-endian
// word count, then big-endian 32-bit words) into sequential instruction-memory
// writes and holds the CPU in reset until the whole image has landed.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and the CHECK state that verifies it.
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are
// both high; in_ready depends only on the state register, never on in_valid.
`timescale 1ns/1ps
module imem_loader #(
  parameter int INSTR_MEM_SIZE = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_HDR_HI  = 3'd0,
    S_HDR_LO  = 3'd1,
    S_PAYLOAD = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_hi_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        xfer;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic        last_byte;
  logic        last_word;

  assign xfer      = in_valid & in_ready;
  assign hdr_count = {hdr_hi_q, in_byte};
  assign hdr_bad   = (hdr_count == 16'd0) || ({16'd0, hdr_count} > 32'(INSTR_MEM_SIZE));
  assign last_byte = (byte_cnt_q == 2'd3);
  assign last_word = (word_idx_q == (count_q - 16'd1));
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_HDR_HI;
    else       state_q <= state_d;
  end

  // Next-state and status decode; in_ready is high only while consuming bytes.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_d = hdr_bad ? S_ERROR : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (in_valid && last_byte && last_word) state_d = S_CHECK;
`else
        if (in_valid && last_byte && last_word) state_d = S_FLUSH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (in_byte == xor_q) ? S_FLUSH : S_ERROR;
      end
`endif
      S_FLUSH: state_d = S_DONE;
      S_DONE:  done = 1'b1;
      S_ERROR: error = 1'b1;
      default: state_d = S_HDR_HI;
    endcase
    cpu_reset = ~done;
  end

  // Datapath: header capture, word assembly and the registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_hi_q   <= 8'd0;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (xfer) begin
        case (state_q)
          S_HDR_HI: hdr_hi_q <= in_byte;
          S_HDR_LO: begin
            count_q    <= hdr_count;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
          end
          S_PAYLOAD: begin
            shift_q    <= {shift_q[15:0], in_byte};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ in_byte;
`endif
            if (last_byte) begin
              wr_en      <= 1'b1;
              wr_data    <= {shift_q, in_byte};
              wr_addr    <= {14'd0, word_idx_q, 2'b00};
              word_idx_q <= word_idx_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
